// File: rtl/counter_bank.sv
// Bank of NCH independent up/down counters with wrap/saturate, compare and sticky
// flags, programmed over a valid/ready/wstrb register bus, with an LA load port.
module counter_bank #(
    parameter int BITS   = 32,
    parameter int NCH    = 4,
    parameter int ADDR_W = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                valid,
    input  logic [3:0]          wstrb,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [31:0]         wdata,
    output logic                ready,
    output logic [31:0]         rdata,
    input  logic [3:0]          la_ch,
    input  logic [BITS-1:0]     la_write,
    input  logic [BITS-1:0]     la_input,
    output logic [NCH*BITS-1:0] count,
    output logic                irq
);
    localparam int CH_W = ADDR_W - 4;
    localparam logic [BITS-1:0] MAX = '1;
    localparam logic [BITS-1:0] ONE = BITS'(1);

    logic                       ready_reg;
    logic                       irq_reg;
    logic [31:0]                rdata_reg;
    logic [31:0]                rdata_next;
    logic                       accept;
    logic                       is_write;
    logic [CH_W-1:0]            ch;
    logic [1:0]                 word;
    logic [31:0]                strb_mask;
    logic [BITS-1:0]            wmask;
    logic [NCH-1:0]             irq_src;
    logic [NCH-1:0][3:0][31:0]  ch_regs;
    logic                       unused_bits;

    // ready doubles as the busy flag: a request held through the ack cycle is not re-accepted
    assign accept    = valid & ~ready_reg;
    assign is_write  = accept & (wstrb != 4'b0000);
    assign ch        = addr[ADDR_W-1:4];
    assign word      = addr[3:2];
    assign strb_mask = {{8{wstrb[3]}}, {8{wstrb[2]}}, {8{wstrb[1]}}, {8{wstrb[0]}}};
    assign wmask     = strb_mask[BITS-1:0];
    assign unused_bits = ^{addr[1:0], strb_mask, wdata};

    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
        logic [BITS-1:0] count_reg;
        logic [3:0]      ctrl_reg;
        logic [BITS-1:0] cmp_reg;
        logic [1:0]      status_reg;
        logic            sel;
        logic            wr_count;
        logic            la_load;
        logic            step_en;
        logic            at_edge;
        logic [BITS-1:0] stepped;
        logic [1:0]      set_flags;
        logic [1:0]      clr_flags;

        assign sel      = is_write && (ch == CH_W'(gi));
        assign wr_count = sel && (word == 2'd0);
        assign la_load  = (|la_write) && (la_ch == 4'(gi));
        assign step_en  = ctrl_reg[0] && !wr_count && !la_load;

        always_comb begin
            at_edge = ctrl_reg[1] ? (count_reg == '0) : (count_reg == MAX);
            stepped = ctrl_reg[1] ? count_reg - ONE : count_reg + ONE;
            if (at_edge && ctrl_reg[2]) begin
                stepped = count_reg;
            end
        end

        // flags only come from a step that actually lands; bus/LA loads never raise them
        assign set_flags = step_en ? {at_edge, stepped == cmp_reg} : 2'b00;
        assign clr_flags = (sel && word == 2'd3 && wstrb[0]) ? wdata[1:0] : 2'b00;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                count_reg  <= '0;
                ctrl_reg   <= '0;
                cmp_reg    <= '0;
                status_reg <= '0;
            end else begin
                if (wr_count) begin
                    count_reg <= (count_reg & ~wmask) | (wdata[BITS-1:0] & wmask);
                end else if (la_load) begin
                    count_reg <= la_write & la_input;
                end else if (step_en) begin
                    count_reg <= stepped;
                end
                if (sel && word == 2'd1 && wstrb[0]) begin
                    ctrl_reg <= wdata[3:0];
                end
                if (sel && word == 2'd2) begin
                    cmp_reg <= (cmp_reg & ~wmask) | (wdata[BITS-1:0] & wmask);
                end
                status_reg <= (status_reg & ~clr_flags) | set_flags;
            end
        end

        assign count[gi*BITS +: BITS] = count_reg;
        assign irq_src[gi]            = (|status_reg) & ctrl_reg[3];
        assign ch_regs[gi][0]         = 32'(count_reg);
        assign ch_regs[gi][1]         = 32'(ctrl_reg);
        assign ch_regs[gi][2]         = 32'(cmp_reg);
        assign ch_regs[gi][3]         = 32'(status_reg);
    end

    // channels at or above NCH never match and therefore read as zero
    always_comb begin
        rdata_next = '0;
        for (int i = 0; i < NCH; i++) begin
            if (ch == CH_W'(i)) begin
                rdata_next = ch_regs[i][word];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ready_reg <= 1'b0;
            rdata_reg <= '0;
            irq_reg   <= 1'b0;
        end else begin
            ready_reg <= accept;
            if (accept) begin
                rdata_reg <= rdata_next;
            end
            irq_reg <= |irq_src;
        end
    end

    assign ready = ready_reg;
    assign rdata = rdata_reg;
    assign irq   = irq_reg;
endmodule

// File: tb/tb_counter_bank.sv
// Randomized and directed checks of counter_bank against a behavioural model
// of the register bank; the model is compared on every falling clock edge.
module tb_counter_bank;
    localparam int BITS = 32;
    localparam int NCH  = 4;
    localparam longint MAXV = (64'sd1 <<< BITS) - 1;

    logic                clk;
    logic                reset_n;
    logic                valid;
    logic [3:0]          wstrb;
    logic [7:0]          addr;
    logic [31:0]         wdata;
    logic                ready;
    logic [31:0]         rdata;
    logic [3:0]          la_ch;
    logic [BITS-1:0]     la_write;
    logic [BITS-1:0]     la_input;
    logic [NCH*BITS-1:0] count;
    logic                irq;

    int n_cmp = 0;
    int n_bad = 0;
    bit started = 0;

    counter_bank #(.BITS(BITS), .NCH(NCH), .ADDR_W(8)) dut (
        .clk(clk), .reset_n(reset_n), .valid(valid), .wstrb(wstrb), .addr(addr),
        .wdata(wdata), .ready(ready), .rdata(rdata), .la_ch(la_ch),
        .la_write(la_write), .la_input(la_input), .count(count), .irq(irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    longint     m_cnt [NCH];
    logic [3:0] m_ctrl[NCH];
    longint     m_cmp [NCH];
    logic [1:0] m_st  [NCH];
    logic       m_ready;
    logic       m_irq;
    logic [31:0] m_rdata;

    function automatic longint merge(longint cur, logic [3:0] s, logic [31:0] d);
        longint r;
        r = cur;
        for (int b = 0; b < 4; b++) begin
            if (s[b] && 8 * b < BITS) begin
                r = r & ~(longint'(255) << (8 * b));
                r = r | (((longint'(d) >> (8 * b)) & 255) << (8 * b));
            end
        end
        return r;
    endfunction

    function automatic longint rd_model(int c, int w);
        if (c >= NCH) return 0;
        case (w)
            0: return m_cnt[c];
            1: return longint'(m_ctrl[c]);
            2: return m_cmp[c];
            default: return longint'(m_st[c]);
        endcase
    endfunction

    int     mc;
    int     mw;
    bit     macc;
    bit     mwr;
    bit     mirq;
    longint nv;
    logic [1:0] setf;
    logic [1:0] clrf;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int c = 0; c < NCH; c++) begin
                m_cnt[c] = 0; m_ctrl[c] = '0; m_cmp[c] = 0; m_st[c] = '0;
            end
            m_ready = 1'b0; m_irq = 1'b0; m_rdata = '0;
        end else begin
            mc   = int'(addr[7:4]);
            mw   = int'(addr[3:2]);
            macc = valid && !m_ready;
            mwr  = macc && (wstrb != 4'b0);
            mirq = 1'b0;
            for (int c = 0; c < NCH; c++) begin
                if (m_st[c] != 2'b00 && m_ctrl[c][3]) mirq = 1'b1;
            end
            if (macc) begin
                m_rdata = 32'(rd_model(mc, mw));
                $display("txn t=%0t %s ch=%0d word=%0d wstrb=%h wdata=%h rdata=%h",
                         $time, mwr ? "WR" : "RD", mc, mw, wstrb, wdata, m_rdata);
            end
            for (int c = 0; c < NCH; c++) begin
                setf = 2'b00;
                if (mwr && mc == c && mw == 0) begin
                    m_cnt[c] = merge(m_cnt[c], wstrb, wdata);
                end else if (la_write != '0 && int'(la_ch) == c) begin
                    m_cnt[c] = longint'(la_write & la_input);
                end else if (m_ctrl[c][0]) begin
                    nv = m_ctrl[c][1] ? m_cnt[c] - 1 : m_cnt[c] + 1;
                    if (nv < 0 || nv > MAXV) begin
                        setf[1] = 1'b1;
                        nv = m_ctrl[c][2] ? m_cnt[c] : (nv & MAXV);
                    end
                    if (nv == m_cmp[c]) setf[0] = 1'b1;
                    m_cnt[c] = nv;
                end
                clrf = (mwr && mc == c && mw == 3 && wstrb[0]) ? wdata[1:0] : 2'b00;
                m_st[c] = (m_st[c] & ~clrf) | setf;
                if (mwr && mc == c && mw == 1 && wstrb[0]) m_ctrl[c] = wdata[3:0];
                if (mwr && mc == c && mw == 2) m_cmp[c] = merge(m_cmp[c], wstrb, wdata);
            end
            m_irq   = mirq;
            m_ready = macc;
        end
    end

    always @(negedge clk) begin
        if (started && reset_n) begin
            for (int c = 0; c < NCH; c++) begin
                chk($sformatf("model_count%0d", c), 64'(count[c*BITS +: BITS]), m_cnt[c]);
            end
            chk("model_ready", 64'(ready), 64'(m_ready));
            chk("model_irq", 64'(irq), 64'(m_irq));
            chk("model_rdata", 64'(rdata), 64'(m_rdata));
        end
    end

    // ---------------- stimulus ----------------
    function automatic logic [7:0] ra(int c, int w);
        return 8'(c * 16 + w * 4);
    endfunction

    task automatic bus(input logic [3:0] s, input logic [7:0] a, input logic [31:0] d,
                       output logic [31:0] rd);
        @(negedge clk);
        valid = 1'b1; wstrb = s; addr = a; wdata = d;
        @(negedge clk);
        valid = 1'b0; wstrb = 4'b0;
        rd = rdata;
        chk("bus_ready", 64'(ready), 64'd1);
    endtask

    function automatic logic [31:0] cnt_of(int c);
        return count[c*BITS +: BITS];
    endfunction

    logic [31:0] rd;

    initial begin
        reset_n = 1'b1; valid = 1'b0; wstrb = '0; addr = '0; wdata = '0;
        la_ch = '0; la_write = '0; la_input = '0;
        #3 reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        started = 1'b1;
        chk("reset_count", 64'(count), 64'd0);
        chk("reset_ready", 64'(ready), 64'd0);
        chk("reset_rdata", 64'(rdata), 64'd0);
        chk("reset_irq", 64'(irq), 64'd0);

        // channel 0 free-runs once enabled
        bus(4'hF, ra(0, 1), 32'h1, rd);
        chk("ch0_start", 64'(cnt_of(0)), 64'd0);
        repeat (10) @(negedge clk);
        chk("ch0_after10", 64'(cnt_of(0)), 64'd10);
        chk("ch1_idle", 64'(cnt_of(1)), 64'd0);
        chk("ch3_idle", 64'(cnt_of(3)), 64'd0);
        chk("irq_idle", 64'(irq), 64'd0);

        // channel 1 wraps up with irq enabled
        bus(4'hF, ra(1, 2), 32'h12345678, rd);
        bus(4'hF, ra(1, 0), 32'hFFFFFFFE, rd);
        bus(4'hF, ra(1, 1), 32'h9, rd);
        chk("ch1_load", 64'(cnt_of(1)), 64'hFFFFFFFE);
        @(negedge clk);
        chk("ch1_max", 64'(cnt_of(1)), 64'hFFFFFFFF);
        @(negedge clk);
        chk("ch1_wrap", 64'(cnt_of(1)), 64'h0);
        chk("ch1_irq_lag", 64'(irq), 64'd0);
        @(negedge clk);
        chk("ch1_irq", 64'(irq), 64'd1);
        bus(4'h0, ra(1, 3), 32'h0, rd);
        chk("ch1_status", 64'(rd), 64'h2);
        bus(4'hF, ra(1, 3), 32'h2, rd);
        chk("ch1_irq_hold", 64'(irq), 64'd1);
        @(negedge clk);
        chk("ch1_irq_clr", 64'(irq), 64'd0);

        // channel 2 saturating down
        bus(4'hF, ra(2, 2), 32'h55, rd);
        bus(4'hF, ra(2, 0), 32'h1, rd);
        bus(4'hF, ra(2, 1), 32'h7, rd);
        chk("ch2_load", 64'(cnt_of(2)), 64'd1);
        repeat (3) begin
            @(negedge clk);
            chk("ch2_sat", 64'(cnt_of(2)), 64'd0);
        end
        bus(4'h0, ra(2, 3), 32'h0, rd);
        chk("ch2_status", 64'(rd), 64'h2);

        // compare match on channel 0; bus load of CMP value does not match
        bus(4'hF, ra(0, 2), 32'h5, rd);
        bus(4'hF, ra(0, 0), 32'h0, rd);
        chk("ch0_reload", 64'(cnt_of(0)), 64'd0);
        repeat (5) @(negedge clk);
        chk("ch0_at5", 64'(cnt_of(0)), 64'd5);
        bus(4'h0, ra(0, 3), 32'h0, rd);
        chk("ch0_match", 64'(rd), 64'h1);
        bus(4'hF, ra(0, 3), 32'h1, rd);
        bus(4'hF, ra(0, 0), 32'h5, rd);
        bus(4'h0, ra(0, 3), 32'h0, rd);
        chk("ch0_nomatch", 64'(rd), 64'h0);

        // bus COUNT write beats LA load, LA beats step
        bus(4'hF, ra(3, 1), 32'h1, rd);
        @(negedge clk);
        valid = 1'b1; wstrb = 4'h3; addr = ra(3, 0); wdata = 32'h100;
        la_ch = 4'd3; la_write = 32'hFF; la_input = 32'hA5A5A5A5;
        @(negedge clk);
        valid = 1'b0; wstrb = 4'h0;
        chk("ch3_bus_wins", 64'(cnt_of(3)), 64'h100);
        @(negedge clk);
        chk("ch3_la", 64'(cnt_of(3)), 64'hA5);
        la_write = '0;
        @(negedge clk);
        chk("ch3_step", 64'(cnt_of(3)), 64'hA6);

        // out-of-range channel
        bus(4'h0, ra(1, 1), 32'h0, rd);
        chk("ch1_ctrl_rd", 64'(rd), 64'h9);
        bus(4'h0, ra(4, 0), 32'h0, rd);
        chk("oor_read", 64'(rd), 64'h0);

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            valid = ($urandom_range(0, 2) != 0);
            addr  = 8'({$urandom_range(0, 5), 4'($urandom_range(0, 15))});
            wstrb = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
            case ($urandom_range(0, 4))
                0: wdata = 32'h0;
                1: wdata = 32'hFFFFFFFF;
                2: wdata = 32'hFFFFFFFE;
                3: wdata = 32'h1;
                default: wdata = $urandom;
            endcase
            la_ch    = 4'($urandom_range(0, 15));
            la_write = ($urandom_range(0, 5) == 0) ? BITS'($urandom) : '0;
            la_input = BITS'($urandom);
        end
        @(negedge clk);
        valid = 1'b0; wstrb = 4'h0; la_write = '0;
        @(negedge clk);

        // raise irq, then reset in the middle of a transfer
        bus(4'hF, ra(2, 0), 32'h0, rd);
        bus(4'hF, ra(2, 1), 32'hF, rd);
        repeat (3) @(negedge clk);
        chk("pre_reset_irq", 64'(irq), 64'd1);
        @(negedge clk);
        valid = 1'b1; wstrb = 4'h0; addr = ra(0, 0);
        @(posedge clk);
        #1;
        chk("mid_ready", 64'(ready), 64'd1);
        #1 reset_n = 1'b0;
        valid = 1'b0;
        #1;
        chk("async_ready", 64'(ready), 64'd0);
        chk("async_irq", 64'(irq), 64'd0);
        chk("async_count", 64'(count), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_reset_count", 64'(count), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
